// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential integer ALU with a valid/ready request and result port.
//
// Single-cycle ops (add, sub, and, or, xor, shifts) answer one cycle after the
// request is accepted. MUL/MULHU use an iterative shift-add multiplier and, when
// enabled, DIVU/REMU use a restoring divider. Both retire one bit per cycle, so
// the result appears WIDTH+1 cycles after acceptance.
//
// Configuration macro:
//   SEQ_ALU_DIV_EN  when defined, builds the divider and decodes 0x0B/0x0C.
//                   When undefined, 0x0B/0x0C are treated as undefined opcodes.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    request valid
//   o_ready    request accepted when i_valid && o_ready (high only when idle)
//   i_command  8-bit opcode
//   i_a, i_b   WIDTH-bit operands
//   o_valid    result valid
//   i_ready    result consumed when o_valid && i_ready
//   o_out      registered result
//   o_zero     high when o_out == 0
//   o_err      undefined-opcode flag, qualified by o_valid
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_command,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zero,
    output logic             o_err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_AND   = 8'h03;
    localparam logic [7:0] OP_OR    = 8'h04;
    localparam logic [7:0] OP_XOR   = 8'h05;
    localparam logic [7:0] OP_SRL   = 8'h06;
    localparam logic [7:0] OP_SRA   = 8'h07;
    localparam logic [7:0] OP_SLL   = 8'h08;
    localparam logic [7:0] OP_MUL   = 8'h09;
    localparam logic [7:0] OP_MULHU = 8'h0A;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [7:0] OP_DIVU  = 8'h0B;
    localparam logic [7:0] OP_REMU  = 8'h0C;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched request and iterative datapath state. hi/lo form one 2*WIDTH
    // register: product {hi,lo} for multiply, {remainder,quotient} for divide.
    logic [7:0]       cmd_p0;
    logic [WIDTH-1:0] opnd_p0;
    logic [WIDTH-1:0] hi_p0;
    logic [WIDTH-1:0] lo_p0;
    logic [SHW-1:0]   cnt_p0;
    logic [WIDTH-1:0] out_q;
    logic             err_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] multi_res;
    logic [WIDTH:0]   single_res;

    // Opcodes that use the iterative datapath.
    function automatic logic is_multi(input logic [7:0] cmd);
        logic r;
        r = (cmd == OP_MUL) || (cmd == OP_MULHU);
`ifdef SEQ_ALU_DIV_EN
        r = r || (cmd == OP_DIVU) || (cmd == OP_REMU);
`endif
        return r;
    endfunction

`ifdef SEQ_ALU_DIV_EN
    function automatic logic is_div(input logic [7:0] cmd);
        return (cmd == OP_DIVU) || (cmd == OP_REMU);
    endfunction
`endif

    // Single-cycle result as {err, value}. Only the low SHW bits of b form the
    // shift amount. Anything not handled here or by the iterative path is an
    // undefined opcode and yields zero with the error flag.
    function automatic logic [WIDTH:0] single_op(input logic [7:0]       cmd,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [SHW-1:0]          sh;
        logic signed [WIDTH-1:0] sa;
        logic [WIDTH:0]          r;
        sh = b[SHW-1:0];
        sa = a;
        r  = '0;
        case (cmd)
            OP_ADD:  r = {1'b0, a + b};
            OP_SUB:  r = {1'b0, a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SRL:  r = {1'b0, a >> sh};
            OP_SRA:  r = {1'b0, WIDTH'(sa >>> sh)};
            OP_SLL:  r = {1'b0, a << sh};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    assign accept     = i_valid && (state == S_IDLE);
    assign last_step  = (cnt_p0 == SHW'(WIDTH - 1));
    assign single_res = single_op(i_command, i_a, i_b);

    // One iteration of the shared multiply/divide datapath.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        // Shift-add multiply: conditionally add the multiplicand to the upper
        // half, then shift the whole product right, carry included.
        sum     = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opnd_p0} : '0);
        hi_nxt  = sum[WIDTH:1];
        lo_nxt  = {sum[0], lo_p0[WIDTH-1:1]};
        shifted = {hi_p0, lo_p0[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_p0};
`ifdef SEQ_ALU_DIV_EN
        // Restoring divide: shift the next dividend bit into the remainder and
        // keep the subtraction only if it does not go negative. A zero divisor
        // always subtracts, giving an all-ones quotient and remainder = a.
        if (is_div(cmd_p0)) begin
            if (shifted >= {1'b0, opnd_p0}) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {lo_p0[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo_p0[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        multi_res = lo_nxt;
        if (cmd_p0 == OP_MULHU) multi_res = hi_nxt;
`ifdef SEQ_ALU_DIV_EN
        if (cmd_p0 == OP_REMU) multi_res = hi_nxt;
`endif
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = is_multi(i_command) ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (last_step) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, iteration and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_p0  <= '0;
            opnd_p0 <= '0;
            hi_p0   <= '0;
            lo_p0   <= '0;
            cnt_p0  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cmd_p0 <= i_command;
                cnt_p0 <= '0;
                hi_p0  <= '0;
                if (is_multi(i_command)) begin
                    opnd_p0 <= i_a;
                    lo_p0   <= i_b;
`ifdef SEQ_ALU_DIV_EN
                    // Divide keeps the divisor as operand and shifts the
                    // dividend out of lo while the quotient shifts in.
                    if (is_div(i_command)) begin
                        opnd_p0 <= i_b;
                        lo_p0   <= i_a;
                    end
`endif
                end else begin
                    out_q <= single_res[WIDTH-1:0];
                    err_q <= single_res[WIDTH];
                end
            end
            if (state == S_BUSY) begin
                hi_p0  <= hi_nxt;
                lo_p0  <= lo_nxt;
                cnt_p0 <= cnt_p0 + SHW'(1);
                if (last_step) begin
                    out_q <= multi_res;
                    err_q <= 1'b0;
                end
            end
        end
    end

    assign o_out  = out_q;
    assign o_zero = (out_q == '0);
    assign o_err  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH=32). Directed corner
// cases plus randomized requests, each compared against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_command;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_out;
    logic        o_zero;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(32)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_command (i_command),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_out     (o_out),
        .o_zero    (o_zero),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the opcode definitions.
    task automatic model(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
        logic [63:0] p;
        int          sh;
        sh  = int'(b % 32);
        p   = {32'b0, a} * {32'b0, b};
        r   = '0;
        e   = 1'b0;
        lat = 1;
        case (cmd)
            8'h01: r = a + b;
            8'h02: r = a - b;
            8'h03: r = a & b;
            8'h04: r = a | b;
            8'h05: r = a ^ b;
            8'h06: r = a >> sh;
            8'h07: r = $signed(a) >>> sh;
            8'h08: r = a << sh;
            8'h09: begin r = p[31:0];  lat = 33; end
            8'h0A: begin r = p[63:32]; lat = 33; end
`ifdef SEQ_ALU_DIV_EN
            8'h0B: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
            8'h0C: begin r = (b == 0) ? a : a % b;             lat = 33; end
`endif
            default: e = 1'b1;
        endcase
    endtask

    // Issue one request (called just after a falling edge), wait for the
    // result, optionally stall the consumer, then consume it while i_valid is
    // held high to confirm nothing is accepted in the consuming cycle.
    task automatic do_op(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
        logic [31:0] er;
        logic        ee;
        int          el;
        int          lat;
        bit          got;
        model(cmd, a, b, er, ee, el);
        chk("ready_before", o_ready, 1);
        i_command = cmd;
        i_a       = a;
        i_b       = b;
        i_valid   = 1'b1;
        lat       = 0;
        got       = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            i_valid   = 1'b0;
            i_a       = $urandom;
            i_b       = $urandom;
            i_command = 8'($urandom);
            if (o_valid) begin
                got = 1;
                break;
            end
        end
        chk($sformatf("latency op%0h", cmd), lat, el);
        if (!got) return;
        chk("ready_in_done", o_ready, 0);
        chk($sformatf("out op%0h a=%0h b=%0h", cmd, a, b), o_out, er);
        chk("zero", o_zero, (er == 0));
        chk("err", o_err, ee);
        for (int k = 0; k < stall; k++) begin
            i_valid   = 1'($urandom);
            i_command = 8'h01;
            @(negedge clk);
            chk("stall_valid", o_valid, 1);
            chk("stall_ready", o_ready, 0);
            chk("stall_out", o_out, er);
            chk("stall_err", o_err, ee);
        end
        i_ready   = 1'b1;
        i_valid   = 1'b1;
        i_command = 8'h01;
        @(negedge clk);
        chk("consume_valid", o_valid, 0);
        chk("consume_ready", o_ready, 1);
        i_ready = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_command = '0;
        i_a       = '0;
        i_b       = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_out", o_out, 0);
        chk("rst_zero", o_zero, 1);
        chk("rst_err", o_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        do_op(8'h01, 32'hFFFF_FFFF, 32'h1, 0);
        do_op(8'h07, 32'h8000_0000, 32'h24, 0);
        do_op(8'h06, 32'h8000_0000, 32'h1F, 0);
        do_op(8'h08, 32'h0000_0001, 32'h3F, 0);
        do_op(8'h02, 32'h0, 32'h1, 0);
        do_op(8'h09, 32'h0001_0000, 32'h0001_0000, 0);
        do_op(8'h0A, 32'h0001_0000, 32'h0001_0000, 0);
        do_op(8'h0A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(8'h0B, 32'd100, 32'd7, 0);
        do_op(8'h0C, 32'd100, 32'd7, 0);
        do_op(8'h0B, 32'd5, 32'd0, 0);
        do_op(8'h0C, 32'd5, 32'd0, 0);
        do_op(8'h0B, 32'hFFFF_FFFF, 32'h1, 0);
        do_op(8'h03, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);
        do_op(8'hFF, 32'h1234_5678, 32'h9, 5);
        do_op(8'h00, 32'h1, 32'h1, 0);

        // Reset while the multiplier is in its tenth busy cycle
        chk("abort_ready", o_ready, 1);
        i_command = 8'h09;
        i_a       = 32'h1234_5678;
        i_b       = 32'h9ABC_DEF0;
        i_valid   = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_ready", o_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", o_valid, 0);
        chk("abort_ready_rst", o_ready, 1);
        chk("abort_out", o_out, 0);
        chk("abort_zero", o_zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h01, 32'd2, 32'd3, 0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom % 16);
            if (r < 12) cmd = 8'(r + 1);
            else if (r == 12) cmd = 8'h00;
            else cmd = 8'(8'h0D + ($urandom % 243));
            a = $urandom;
            b = $urandom;
            case ($urandom % 6)
                0: a = '0;
                1: b = '0;
                2: b = $urandom % 40;
                3: a = 32'h8000_0000 | $urandom;
                default: ;
            endcase
            do_op(cmd, a, b, int'($urandom % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit in case the DUT wedges in a way the per-op bounds miss.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width; legal values are powers of two >= 8.
REQ-002 SHALL derive SHW = log2(WIDTH) as the shift-amount width; it is not user-overridable.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  request accepted when i_valid&&o_ready.
REQ-007 SHALL have port i_command  input  8  opcode.
REQ-008 SHALL have ports i_a, i_b  input  WIDTH  operands.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  result consumed when o_valid&&i_ready.
REQ-011 SHALL have port o_out  output  WIDTH  result, registered.
REQ-012 SHALL have port o_zero  output  1  (o_out == 0).
REQ-013 SHALL have port o_err  output  1  undefined opcode flag, valid with o_valid.

Function
REQ-014 SHALL implement FSM IDLE -> (BUSY) -> DONE -> IDLE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-015 SHALL latch i_command, i_a, i_b on accept; input changes after accept have no effect.
REQ-016 SHALL execute single-cycle ops: 0x01 a+b, 0x02 a-b (both mod 2^WIDTH), 0x03 and, 0x04 or, 0x05 xor, 0x06 a>>b[SHW-1:0] logical, 0x07 arithmetic right shift, 0x08 a<<b[SHW-1:0].
REQ-017 SHALL, for single-cycle ops, go IDLE->DONE on the accepting edge (o_valid high the cycle after accept, latency 1).
REQ-018 SHALL execute 0x09 MUL (low WIDTH bits of unsigned a*b) and 0x0A MULHU (high WIDTH bits) by iterative shift-add, one bit per cycle.
REQ-019 SHALL execute 0x0B DIVU (unsigned quotient) and 0x0C REMU (unsigned remainder) by restoring division, one bit per cycle.
REQ-020 SHALL, for ops 0x09-0x0C, run BUSY for exactly WIDTH cycles, then DONE; o_valid rises WIDTH+1 cycles after the accepting edge.
REQ-021 SHALL, on divide by zero, return DIVU = all-ones and REMU = a, o_err=0, same latency.
REQ-022 SHALL, on any other opcode, return o_out=0, o_err=1, latency 1.
REQ-023 SHALL hold o_out, o_zero, o_err stable in DONE while i_ready=0.
REQ-024 SHALL, on o_valid&&i_ready, return to IDLE next edge; no new request is accepted in that same cycle.
REQ-025 SHALL ignore i_valid whenever o_ready=0.

Reset
REQ-026 SHALL, while i_rst_n=0, force state IDLE: o_ready=1, o_valid=0, o_out=0, o_zero=1, o_err=0.
REQ-027 SHALL abort any BUSY/DONE operation on reset with no result emitted; the first request after release executes normally.

Configuration
REQ-028 SHALL compile divide logic only when macro SEQ_ALU_DIV_EN is defined; then 0x0B/0x0C behave per REQ-019..021.
REQ-029 SHALL, without SEQ_ALU_DIV_EN, treat 0x0B/0x0C as undefined opcodes per REQ-022; MUL/MULHU unaffected.

Verification (WIDTH=32)
REQ-030 SHALL check ADD a=0xFFFFFFFF b=1 -> o_out=0, o_zero=1, o_err=0, o_valid 1 cycle after accept.
REQ-031 SHALL check op 0x07 a=0x80000000 b=0x24 -> o_out=0xF8000000 (shift 4, upper b bits ignored).
REQ-032 SHALL check MUL/MULHU a=b=0x00010000 -> 0x00000000 / 0x00000001, o_valid 33 cycles after accept.
REQ-033 SHALL check DIVU/REMU 100,7 -> 14 / 2; DIVU 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5; with SEQ_ALU_DIV_EN undefined, DIVU -> o_out=0, o_err=1, latency 1.
REQ-034 SHALL check i_ready=0 for 5 cycles in DONE -> outputs stable, o_ready=0, i_valid pulses dropped; opcode 0xFF -> o_err=1.
REQ-035 SHALL check reset at BUSY cycle 10 of MUL -> o_valid=0, o_ready=1; subsequent ADD 2+3 -> 5.
